// File: rtl/prewish_mask_sequencer.sv
// Strobe/mask responder: queues 8-bit blink masks in a small FIFO and plays them MSB-first on o_led.
// Optional build macro PREWISH_SEQ_LOOP_EN: repeat the last popped mask while the FIFO is empty.
module prewish_mask_sequencer #(
    parameter int SYSCLK_DIV_BITS = 19,
    parameter int FIFO_AW         = 2
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic       o_drop,
    output logic       o_led,
    output logic       o_busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]         PTR_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [SYSCLK_DIV_BITS-1:0] TICK_ONE = SYSCLK_DIV_BITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                     state_reg;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_AW:0]           wr_ptr_reg;
    logic [FIFO_AW:0]           rd_ptr_reg;
    logic                       stb_last_reg;
    logic [SYSCLK_DIV_BITS-1:0] tick_ct_reg;
    logic [7:0]                 shreg_reg;
    logic [2:0]                 bitcnt_reg;
    logic                       ack_reg;
    logic                       drop_reg;
    logic                       led_reg;
    logic                       busy_reg;

    logic       empty;
    logic       full;
    logic       wr_req;
    logic       pop;
    logic       wr_en;
    logic       tick;
    logic [7:0] head;
    logic [7:0] load_src;

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                    (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
    assign wr_req = STB_I & ~stb_last_reg;
    assign pop    = (state_reg == LOAD) && !empty;
    // A pop in the same cycle frees a slot, so a write against a full FIFO still lands.
    assign wr_en  = wr_req && (!full || pop);
    assign tick   = &tick_ct_reg;
    assign head   = mem[rd_ptr_reg[FIFO_AW-1:0]];

`ifdef PREWISH_SEQ_LOOP_EN
    logic [7:0] last_mask_reg;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            last_mask_reg <= '0;
        end else if (pop) begin
            last_mask_reg <= head;
        end
    end

    assign load_src = empty ? last_mask_reg : head;
`else
    assign load_src = head;
`endif

    always_ff @(posedge CLK_I) begin
        if (wr_en && !RST_I) begin
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= DAT_I;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            stb_last_reg <= 1'b1;
            tick_ct_reg  <= '0;
            shreg_reg    <= '0;
            bitcnt_reg   <= '0;
            ack_reg      <= 1'b0;
            drop_reg     <= 1'b0;
            led_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            stb_last_reg <= STB_I;
            ack_reg      <= wr_en;
            drop_reg     <= wr_req && !wr_en;
            tick_ct_reg  <= tick_ct_reg + TICK_ONE;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end

            case (state_reg)
                IDLE: begin
                    led_reg <= 1'b0;
                    if (!empty) begin
                        state_reg <= LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    // Clearing the divider here gives every bit a full tick period.
                    tick_ct_reg <= '0;
                    shreg_reg   <= load_src;
                    led_reg     <= load_src[7];
                    bitcnt_reg  <= '0;
                    state_reg   <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (bitcnt_reg == 3'd7) begin
                            led_reg <= 1'b0;
                            if (!empty) begin
                                state_reg <= LOAD;
                            end else begin
`ifdef PREWISH_SEQ_LOOP_EN
                                state_reg <= LOAD;
`else
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
`endif
                            end
                        end else begin
                            shreg_reg  <= {shreg_reg[6:0], 1'b0};
                            led_reg    <= shreg_reg[6];
                            bitcnt_reg <= bitcnt_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    led_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign ACK_O  = ack_reg;
    assign o_drop = drop_reg;
    assign o_led  = led_reg;
    assign o_busy = busy_reg;

endmodule

// File: tb/tb_prewish_mask_sequencer.sv
// Bench for prewish_mask_sequencer: queue/timeline reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_prewish_mask_sequencer;

    localparam int DIVB  = 3;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int BITC  = 8;           // cycles per bit = 2**DIVB
    localparam int LASTT = 8 * BITC;    // timeline index of the final shift cycle
`ifdef PREWISH_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       ack;
    logic       drop;
    logic       led;
    logic       busy;

    always #5 clk = ~clk;

    prewish_mask_sequencer #(
        .SYSCLK_DIV_BITS(DIVB),
        .FIFO_AW        (AW)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .STB_I (stb),
        .DAT_I (dat),
        .ACK_O (ack),
        .o_drop(drop),
        .o_led (led),
        .o_busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int ack_total = 0;
    int drop_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, playback as a position t on a 65-cycle timeline
    // (t=0 is the load cycle, t=1..64 are the shift cycles of bit (t-1)/8).
    logic [7:0] q[$];
    logic       m_stb_prev;
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;
    logic [7:0] m_last;
    logic       exp_ack, exp_drop, exp_led, exp_busy;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin : model
        int pre;
        bit wr, popping, accept;
        if (rst) begin
            q.delete();
            m_stb_prev = 1'b1;
            m_active = 1'b0;
            m_t = 0;
            m_cur = 8'h00;
            m_last = 8'h00;
            exp_ack = 1'b0;
            exp_drop = 1'b0;
            exp_led = 1'b0;
            exp_busy = 1'b0;
            chk_en = 1'b1;
        end else begin
            pre = q.size();
            wr = stb && !m_stb_prev;
            popping = m_active && (m_t == 0) && (pre > 0);
            accept = wr && ((pre < DEPTH) || popping);
            if (m_active && m_t == 0) begin
                if (pre > 0) begin
                    m_cur = q.pop_front();
                    m_last = m_cur;
                end else begin
                    m_cur = m_last;
                end
            end
            if (accept) q.push_back(dat);
            if (!m_active) begin
                if (pre > 0) begin
                    m_active = 1'b1;
                    m_t = 0;
                end
            end else if (m_t == LASTT) begin
                if (pre > 0 || LOOP) m_t = 0;
                else m_active = 1'b0;
            end else begin
                m_t++;
            end
            exp_led = (m_active && m_t >= 1) ? m_cur[7 - (m_t - 1) / BITC] : 1'b0;
            exp_busy = m_active;
            exp_ack = accept;
            exp_drop = wr && !accept;
            m_stb_prev = stb;
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("model_ack", ack, exp_ack);
            check("model_drop", drop, exp_drop);
            check("model_led", led, exp_led);
            check("model_busy", busy, exp_busy);
        end
        if (ack === 1'b1) ack_total++;
        if (drop === 1'b1) drop_total++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] d, input int hold);
        stb = 1'b1;
        dat = d;
        step(hold);
        stb = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < bound), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        logic [7:0] pat;
        int a0, d0;
        logic lv [130];

        rst = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ack", ack, 0);
        check("reset_drop", drop, 0);
        check("reset_led", led, 0);
        check("reset_busy", busy, 0);
        step(1);

`ifndef PREWISH_SEQ_LOOP_EN
        // Single mask: ACK next cycle, bits from the third cycle after the write, 8 cycles each.
        pat = 8'b10101000;
        a0 = ack_total;
        strobe(pat, 1);
        @(negedge clk);
        check("t1_ack", ack, 1);
        step(2);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            check("t1_led", led, pat[7 - k / 8]);
            step(1);
        end
        @(negedge clk);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_led", led, 0);
        check("t1_ack_count", ack_total - a0, 1);
        step(1);

        // Long strobe gives exactly one write.
        a0 = ack_total;
        strobe(8'b11001010, 811);
        wait_idle(1000);
        check("long_ack_count", ack_total - a0, 1);

        // Five strobes two cycles apart from IDLE: all accepted.
        a0 = ack_total;
        d0 = drop_total;
        for (int i = 0; i < 5; i++) begin
            strobe(8'($urandom), 1);
            step(1);
        end
        wait_idle(1000);
        check("five_ack_count", ack_total - a0, 5);
        check("five_drop_count", drop_total - d0, 0);

        // Fill during playback, overflow, then write exactly on the next load cycle.
        a0 = ack_total;
        d0 = drop_total;
        strobe(8'b10000001, 1);
        step(9);
        for (int i = 0; i < 5; i++) begin
            strobe(8'(8'h11 * (i + 2)), 1);
            if (i < 4) step(1);
        end
        @(negedge clk);
        check("full_drop", drop, 1);
        check("full_noack", ack, 0);
        step(48);
        strobe(8'b01111110, 1);
        @(negedge clk);
        check("load_pop_ack", ack, 1);
        wait_idle(1000);
        check("fill_ack_count", ack_total - a0, 6);
        check("fill_drop_count", drop_total - d0, 1);

        // Reset during bit 3 with strobe held high across release.
        strobe(8'b11110000, 1);
        step(29);
        stb = 1'b1;
        dat = 8'hA5;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        a0 = ack_total;
        step(20);
        check("rst_held_noack", ack_total - a0, 0);
        stb = 1'b0;
        step(1);
        strobe(8'b00110011, 1);
        @(negedge clk);
        check("rst_rearm_ack", ack, 1);
        wait_idle(1000);

        // Randomized traffic, including overflows.
        for (int i = 0; i < 30; i++) begin
            strobe(8'($urandom), int'($urandom_range(1, 3)));
            step(int'($urandom_range(1, 70)));
        end
        wait_idle(2000);
`else
        // Loop build: one mask repeats every 65 cycles until a new one takes over.
        pat = 8'b11100000;
        strobe(pat, 1);
        step(2);
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            lv[k] = led;
            step(1);
        end
        for (int k = 0; k < 130; k++)
            check("loop_led", lv[k], ((k % 65) < 64) ? pat[7 - (k % 65) / 8] : 1'b0);
        check("loop_busy", busy, 1);
        strobe(8'b10000000, 1);
        step(64);
        @(negedge clk);
        check("takeover_bit7", led, 1);
        step(8);
        @(negedge clk);
        check("takeover_bit6", led, 0);
        step(200);
        check("loop_busy_end", busy, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
